// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the queued PC generator.
//   XLEN_DEFAULT  default PC / address width
//   state_e       generator FSM states (idle, boot, run)
//   redir_src_e   redirect source, ordered by priority
//   redir_select  fixed-priority encoder: mret > irq > jump/branch
package pc_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BOOT = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RS_NONE = 2'd0,
    RS_BR   = 2'd1,
    RS_IRQ  = 2'd2,
    RS_MRET = 2'd3
  } redir_src_e;

  // Highest-priority redirect source among the request lines.
  function automatic redir_src_e redir_select(input logic mret,
                                              input logic irq,
                                              input logic jmp_br);
    if (mret) begin
      return RS_MRET;
    end else if (irq) begin
      return RS_IRQ;
    end else if (jmp_br) begin
      return RS_BR;
    end else begin
      return RS_NONE;
    end
  endfunction

endpackage

// File: rtl/pc_fifo.sv
// pc_fifo: pointer-based FIFO with flush, async active-low reset.
// Head data is read combinationally (zero-latency).
//   clk_i, reset_ni   clock / async active-low reset
//   flush_i           empties the FIFO (wins over push/pop)
//   push_i, wdata_i   enqueue; accepted when not full or when popping
//   pop_i             dequeue; ignored when empty
//   rdata_o           head entry
//   full_o, empty_o   occupancy flags
//   count_o           number of occupied entries (0..DEPTH)
module pc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Qualify requests so the FIFO never underflows or overflows on its own.
  always_comb begin
    pop_ok_s  = 1'b0;
    push_ok_s = 1'b0;
    if (flush_i) begin
      pop_ok_s  = 1'b0;
      push_ok_s = 1'b0;
    end else begin
      pop_ok_s  = pop_i & ~empty_o;
      // A push into a full FIFO is fine when the head leaves the same cycle.
      push_ok_s = push_i & (~full_o | pop_ok_s);
    end
  end

  // Storage, pointers and occupancy counter.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else if (flush_i) begin
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push_ok_s && !pop_ok_s) begin
        count_q <= count_q + CW'(1);
      end else if (pop_ok_s && !push_ok_s) begin
        count_q <= count_q - CW'(1);
      end else begin
        count_q <= count_q;
      end
    end
  end

endmodule

// File: rtl/pc_gen_q.sv
// pc_gen_q: PC generator that runs ahead of fetch and buffers up to DEPTH
// sequential PCs. Redirects (mret > irq > jump/branch) flush the queue and
// restart generation from the selected target.
//   clk_i, reset_ni          clock / async active-low reset
//   enable_design            global run enable (gates boot and enqueue)
//   initial_pc_i             boot PC, sampled in BOOT
//   jump_inst_i, branch_inst_i, target_pc_i    jump/branch redirect
//   irq_prep_i, interrupt_vector_i             interrupt redirect
//   mret_inst_i, mepc_i                        trap-return redirect
//   pc_o, pc_valid_o, pc_ready_i               head of queue handshake
//   gen_pc_o                 next PC to be enqueued
//   count_o                  occupied queue entries
//   redirect_o               registered pulse one cycle after a redirect
module pc_gen_q
  import pc_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int DEPTH       = 4,
  parameter int STEP        = 4,
  parameter int debug_param = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   enable_design,
  input  logic [XLEN-1:0]        initial_pc_i,
  input  logic                   jump_inst_i,
  input  logic                   branch_inst_i,
  input  logic [XLEN-1:0]        target_pc_i,
  input  logic                   irq_prep_i,
  input  logic [XLEN-1:0]        interrupt_vector_i,
  input  logic                   mret_inst_i,
  input  logic [XLEN-1:0]        mepc_i,
  output logic [XLEN-1:0]        pc_o,
  output logic                   pc_valid_o,
  input  logic                   pc_ready_i,
  output logic [XLEN-1:0]        gen_pc_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   redirect_o
);

  localparam logic [XLEN-1:0] STEP_X = XLEN'(STEP);

  state_e            state_q;
  logic [XLEN-1:0]   gen_pc_q;
  logic              redirect_q;

  redir_src_e        redir_src_s;
  logic              redir_take_s;
  logic [XLEN-1:0]   target_s;
  logic              pop_s;
  logic              push_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;

  // Redirect arbitration and queue handshake decisions.
  always_comb begin
    redir_src_s  = redir_select(mret_inst_i, irq_prep_i,
                                jump_inst_i | branch_inst_i);
    redir_take_s = (state_q == S_RUN) && (redir_src_s != RS_NONE);
    target_s     = gen_pc_q;
    case (redir_src_s)
      RS_MRET: target_s = mepc_i;
      RS_IRQ:  target_s = interrupt_vector_i;
      RS_BR:   target_s = target_pc_i;
      default: target_s = gen_pc_q;
    endcase
    // A pop coinciding with a redirect is dropped along with the queue.
    pop_s  = ~fifo_empty_s & pc_ready_i & ~redir_take_s;
    push_s = (state_q == S_RUN) & ~redir_take_s & enable_design
             & (~fifo_full_s | pop_s);
  end

  // FSM, generator register and registered redirect pulse.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      gen_pc_q   <= {XLEN{1'b0}};
      redirect_q <= 1'b0;
    end else begin
      redirect_q <= redir_take_s;
      case (state_q)
        S_IDLE: begin
          if (enable_design) begin
            state_q <= S_BOOT;
          end
        end
        S_BOOT: begin
          gen_pc_q <= initial_pc_i;
          state_q  <= S_RUN;
        end
        S_RUN: begin
          if (redir_take_s) begin
            gen_pc_q <= target_s;
          end else if (push_s) begin
            gen_pc_q <= gen_pc_q + STEP_X;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  pc_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .flush_i  (redir_take_s),
    .push_i   (push_s),
    .wdata_i  (gen_pc_q),
    .pop_i    (pop_s),
    .rdata_o  (pc_o),
    .full_o   (fifo_full_s),
    .empty_o  (fifo_empty_s),
    .count_o  (count_o)
  );

  assign pc_valid_o = ~fifo_empty_s;
  assign gen_pc_o   = gen_pc_q;
  assign redirect_o = redirect_q;

  if (debug_param != 0) begin : g_trace
    // Simulation trace of every redirect taken.
    always_ff @(posedge clk_i) begin
      if (redir_take_s) begin
        $write("pc_gen_q: redirect src=%s target=%h\n",
               redir_src_s.name(), target_s);
      end
    end
  end

endmodule
